cpu_step_ctrl: RTL and testbench

//  Run-control stage directly downstream of the push-button debouncers.

---
 rtl/cpu_step_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
//   Run-control stage that sits behind the push-button debouncers. It turns
//   the single-cycle step/run/halt pulses into a registered clock-enable for
//   the CPU core. It supports single-step (STEP_CYCLES enabled cycles per
//   command), free-run and halt. It stops permanently (until rst) once the
//   core reports that it has executed its halt instruction.
//
// Parameters
//   STEP_CYCLES  cpu_en cycles issued per step command (>= 1)
//   CNT_W        width of the enabled-cycle counter en_cnt
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high; overrides every other input
//   step_pulse   request one step (1-cycle pulse)
//   run_pulse    request free-run (1-cycle pulse)
//   halt_pulse   request halt (1-cycle pulse)
//   cpu_halted   core executed its halt instruction (level or pulse)
//   cpu_en       registered clock-enable to the core
//   state_o      00 IDLE, 01 STEP, 10 RUN, 11 STOP
//   en_cnt       number of cycles with cpu_en=1, wraps silently
//
// Optional feature (macro CPU_STEP_CTRL_BREAK_EN)
//   pc_in        PC of the instruction executing in the current cycle
//   bp_addr      breakpoint address
//   bp_valid     breakpoint armed
//   bp_hit       1-cycle pulse when a breakpoint stops RUN
//   Breakpoints are checked only in RUN. This means a step from a breakpoint
//   address does not immediately re-trigger.

module cpu_step_ctrl #(
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_pulse,
    input  logic             run_pulse,
    input  logic             halt_pulse,
    input  logic             cpu_halted,
`ifdef CPU_STEP_CTRL_BREAK_EN
    input  logic [31:0]      pc_in,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             bp_hit,
`endif
    output logic             cpu_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] en_cnt
);

    // STEP_CYCLES-1 must fit in the remaining-cycle counter.
    localparam int unsigned REM_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        STOP = 2'b11
    } state_e;

    state_e             state_q,  state_d;
    logic               cpu_en_q, cpu_en_d;
    logic [REM_W-1:0]   remain_q, remain_d;
    logic [CNT_W-1:0]   en_cnt_q, en_cnt_d;
    logic               bp_match;
`ifdef CPU_STEP_CTRL_BREAK_EN
    logic               bp_hit_q, bp_hit_d;

    // This match only qualifies an enabled cycle, so the instruction at the
    // breakpoint still completes.
    assign bp_match = cpu_en_q && bp_valid && (pc_in == bp_addr);
`else
    assign bp_match = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cpu_en_q <= 1'b0;
            remain_q <= '0;
            en_cnt_q <= '0;
`ifdef CPU_STEP_CTRL_BREAK_EN
            bp_hit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            remain_q <= remain_d;
            en_cnt_q <= en_cnt_d;
`ifdef CPU_STEP_CTRL_BREAK_EN
            bp_hit_q <= bp_hit_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = cpu_en_q;
        remain_d = remain_q;
        // en_cnt counts the enabled cycle that ends at this edge.
        en_cnt_d = en_cnt_q + CNT_W'(cpu_en_q);
`ifdef CPU_STEP_CTRL_BREAK_EN
        bp_hit_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (cpu_halted) begin
                    state_d  = STOP;
                    cpu_en_d = 1'b0;
                end else if (halt_pulse) begin
                    state_d  = IDLE;
                end else if (run_pulse) begin
                    state_d  = RUN;
                    cpu_en_d = 1'b1;
                end else if (step_pulse) begin
                    state_d  = STEP;
                    cpu_en_d = 1'b1;
                    remain_d = REM_W'(STEP_CYCLES - 1);
                end
            end
            STEP: begin
                // step/run pulses are dropped while a step is in progress.
                if (cpu_halted) begin
                    state_d  = STOP;
                    cpu_en_d = 1'b0;
                end else if (halt_pulse || (remain_q == '0)) begin
                    state_d  = IDLE;
                    cpu_en_d = 1'b0;
                end else begin
                    remain_d = remain_q - REM_W'(1);
                end
            end
            RUN: begin
                if (cpu_halted) begin
                    state_d  = STOP;
                    cpu_en_d = 1'b0;
                end else if (halt_pulse) begin
                    state_d  = IDLE;
                    cpu_en_d = 1'b0;
                end else if (bp_match) begin
                    state_d  = IDLE;
                    cpu_en_d = 1'b0;
`ifdef CPU_STEP_CTRL_BREAK_EN
                    bp_hit_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d  = STOP;
                cpu_en_d = 1'b0;
            end
        endcase
    end

    assign cpu_en  = cpu_en_q;
    assign state_o = state_q;
    assign en_cnt  = en_cnt_q;
`ifdef CPU_STEP_CTRL_BREAK_EN
    assign bp_hit  = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl. The bench runs a few directed scenarios and
// then a randomized pulse stream. Every cycle is compared against a
// behavioural model. The model tracks "running", "steps left" and "stopped"
// rather than an encoded state.

module tb_cpu_step_ctrl;

    localparam int unsigned STEP_CYCLES = 3;
    localparam int unsigned CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             step_pulse = 1'b0;
    logic             run_pulse = 1'b0;
    logic             halt_pulse = 1'b0;
    logic             cpu_halted = 1'b0;
    logic             cpu_en;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] en_cnt;
`ifdef CPU_STEP_CTRL_BREAK_EN
    logic [31:0]      pc_in = '0;
    logic [31:0]      bp_addr = 32'h40;
    logic             bp_valid = 1'b0;
    logic             bp_hit;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model
    bit          m_run;
    bit          m_stop;
    bit          m_hit;
    int unsigned m_left;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.STEP_CYCLES(STEP_CYCLES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_pulse (step_pulse),
        .run_pulse  (run_pulse),
        .halt_pulse (halt_pulse),
        .cpu_halted (cpu_halted),
`ifdef CPU_STEP_CTRL_BREAK_EN
        .pc_in      (pc_in),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .bp_hit     (bp_hit),
`endif
        .cpu_en     (cpu_en),
        .state_o    (state_o),
        .en_cnt     (en_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the model, applied to the inputs sampled at that edge.
    task automatic model_edge();
        bit en_prev;
        en_prev = m_run || (m_left > 0);
        m_hit = 1'b0;
        if (rst) begin
            m_run = 0; m_stop = 0; m_left = 0; m_cnt = 0;
        end else begin
            if (en_prev) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (m_stop) begin
                // sticky until reset
            end else if (cpu_halted) begin
                m_stop = 1; m_run = 0; m_left = 0;
            end else if (halt_pulse) begin
                m_run = 0; m_left = 0;
            end else if (m_run) begin
`ifdef CPU_STEP_CTRL_BREAK_EN
                if (bp_valid && pc_in == bp_addr) begin
                    m_run = 0; m_hit = 1;
                end
`endif
            end else if (m_left > 0) begin
                m_left--;
            end else if (run_pulse) begin
                m_run = 1;
            end else if (step_pulse) begin
                m_left = STEP_CYCLES;
            end
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic ru,
                        input logic h, input logic hd);
        logic [1:0] exp_state;
        rst = r; step_pulse = s; run_pulse = ru; halt_pulse = h; cpu_halted = hd;
        @(posedge clk);
        model_edge();
        #1;
        exp_state = m_stop ? 2'b11 : m_run ? 2'b10 : (m_left > 0) ? 2'b01 : 2'b00;
        check_eq("cpu_en", 64'(cpu_en), 64'(m_run || (m_left > 0)));
        check_eq("state", 64'(state_o), 64'(exp_state));
        check_eq("en_cnt", 64'(en_cnt), 64'(m_cnt));
`ifdef CPU_STEP_CTRL_BREAK_EN
        check_eq("bp_hit", 64'(bp_hit), 64'(m_hit));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for two cycles. Pulses asserted during reset have no effect.
        tick(1, 1, 1, 0, 0);
        tick(1, 1, 0, 1, 0);
        check_eq("rst_en", 64'(cpu_en), 64'd0);
        check_eq("rst_state", 64'(state_o), 64'd0);
        check_eq("rst_cnt", 64'(en_cnt), 64'd0);

        // A single step gives STEP_CYCLES enabled cycles.
        tick(0, 1, 0, 0, 0);
        check_eq("step_first", 64'(state_o), 64'd1);
        for (int i = 0; i < STEP_CYCLES; i++) tick(0, 0, 0, 0, 0);
        check_eq("step_done_en", 64'(cpu_en), 64'd0);
        check_eq("step_cnt", 64'(en_cnt), 64'd3);

        // Run for 10 cycles, with a step pulse ignored in the middle.
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        for (int i = 1; i < 10; i++) tick(0, (i == 5), 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        check_eq("run_halt_en", 64'(cpu_en), 64'd0);
        check_eq("run_halt_state", 64'(state_o), 64'd0);
        check_eq("run_cnt", 64'(en_cnt), 64'd10);

        // cpu_halted together with halt_pulse wins, and STOP is sticky.
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 1);
        check_eq("stop_state", 64'(state_o), 64'd3);
        tick(0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0);
        check_eq("stop_sticky", 64'(state_o), 64'd3);
        tick(1, 0, 0, 0, 0);
        check_eq("stop_rst", 64'(state_o), 64'd0);

        // Counter wrap: 17 enabled cycles read back as 1 with CNT_W=4.
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        check_eq("wrap_cnt", 64'(en_cnt), 64'd1);

`ifdef CPU_STEP_CTRL_BREAK_EN
        // The breakpoint stops RUN. A step from the breakpoint does not re-trigger.
        tick(1, 0, 0, 0, 0);
        bp_valid = 1'b1; bp_addr = 32'h40; pc_in = 32'h10;
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        pc_in = 32'h40;
        tick(0, 0, 0, 0, 0);
        check_eq("bp_hit_pulse", 64'(bp_hit), 64'd1);
        check_eq("bp_en_off", 64'(cpu_en), 64'd0);
        check_eq("bp_state", 64'(state_o), 64'd0);
        tick(0, 1, 0, 0, 0);
        check_eq("bp_step_en", 64'(cpu_en), 64'd1);
        check_eq("bp_hit_clear", 64'(bp_hit), 64'd0);
`endif

        // Randomized pulse stream.
        for (int i = 0; i < 3000; i++) begin
`ifdef CPU_STEP_CTRL_BREAK_EN
            bp_valid = ($urandom_range(0, 3) != 0);
            pc_in    = ($urandom_range(0, 5) == 0) ? bp_addr : 32'($urandom_range(0, 255));
`endif
            tick(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
